// File: rtl/load_store_unit_pkg.sv
// Shared FSM state encoding and funct3 access-size codes for the load/store unit.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, data-memory and load-result bundle of the load/store unit.
// LSU_MISALIGN_TRAP_EN adds the misalign_err signal.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  mem_read;
   logic                  mem_write;
   logic [2:0]            funct3;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;

   logic                  dmem_valid;
   logic                  dmem_ready;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [3:0]            dmem_we;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic                  dmem_rvalid;
   logic [DATA_WIDTH-1:0] dmem_rdata;

   logic                  ld_valid;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  busy;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                  misalign_err;
`endif

   // The unit itself
   modport master (
      input  req_valid, mem_read, mem_write, funct3, addr, wdata,
      input  dmem_ready, dmem_rvalid, dmem_rdata,
      output req_ready, dmem_valid, dmem_addr, dmem_we, dmem_wdata,
      output ld_valid, ld_data, busy
`ifdef LSU_MISALIGN_TRAP_EN
      , output misalign_err
`endif
   );

   // Execute stage plus data memory
   modport slave (
      output req_valid, mem_read, mem_write, funct3, addr, wdata,
      output dmem_ready, dmem_rvalid, dmem_rdata,
      input  req_ready, dmem_valid, dmem_addr, dmem_we, dmem_wdata,
      input  ld_valid, ld_data, busy
`ifdef LSU_MISALIGN_TRAP_EN
      , input misalign_err
`endif
   );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: picks the byte/halfword lane and sign- or zero-extends it.
module lsu_load_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      // addr_lo[0] is ignored for halfwords so misaligned halves fall back to the aligned lane
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
         LSU_BU:  data = {24'd0, byte_sel};
         LSU_H:   data = {{16{half_sel[15]}}, half_sel};
         LSU_HU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access, IDLE -> REQ -> (WAIT -> DONE) -> IDLE.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests on misalign_err instead of issuing them.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   load_store_unit_if.master bus
);

   lsu_state_e            state_q,      state_d;
   logic [2:0]            funct3_q,     funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
   logic                  is_store_q,   is_store_d;
   logic                  dmem_valid_q, dmem_valid_d;
   logic [3:0]            dmem_we_q,    dmem_we_d;
   logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
   logic                  ld_valid_q,   ld_valid_d;
   logic [DATA_WIDTH-1:0] ld_data_q,    ld_data_d;
   logic [DATA_WIDTH-1:0] ld_align;
   logic                  op_req;
   logic                  accept;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                  misalign_err_q, misalign_err_d;
   logic                  misaligned;
`endif

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         LSU_B:   return 4'b0001 << a;
         LSU_H:   return 4'b0011 << {a[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] d);
      case (f3)
         LSU_B:   return {4{d[7:0]}};
         LSU_H:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic st, input logic [2:0] f3,
                                          input logic [1:0] a);
      case (f3)
         LSU_B:   return 1'b0;
         LSU_H:   return a[0];
         LSU_BU:  return st ? (a != 2'd0) : 1'b0;
         LSU_HU:  return st ? (a != 2'd0) : a[0];
         default: return a != 2'd0;
      endcase
   endfunction

   assign misaligned = is_misaligned(bus.mem_write, bus.funct3, bus.addr[1:0]);
`endif

   lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
      .funct3  (funct3_q),
      .addr_lo (addr_q[1:0]),
      .rdata   (bus.dmem_rdata),
      .data    (ld_align)
   );

   assign op_req = bus.req_valid && (bus.mem_read || bus.mem_write);
`ifdef LSU_MISALIGN_TRAP_EN
   assign accept = op_req && !misaligned;
`else
   assign accept = op_req;
`endif

   always_comb begin
      state_d      = state_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      is_store_d   = is_store_q;
      dmem_valid_d = dmem_valid_q;
      dmem_we_d    = dmem_we_q;
      dmem_wdata_d = dmem_wdata_q;
      ld_valid_d   = 1'b0;
      ld_data_d    = ld_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err_d = (state_q == ST_IDLE) && op_req && misaligned;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // mem_write wins when both decode bits are set
               funct3_d     = bus.funct3;
               addr_d       = bus.addr;
               is_store_d   = bus.mem_write;
               dmem_valid_d = 1'b1;
               dmem_we_d    = bus.mem_write ? store_be(bus.funct3, bus.addr[1:0]) : 4'b0000;
               dmem_wdata_d = bus.mem_write ? store_data(bus.funct3, bus.wdata) : '0;
               state_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.dmem_ready) begin
               dmem_valid_d = 1'b0;
               dmem_we_d    = 4'b0000;
               state_d      = is_store_q ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.dmem_rvalid) begin
               ld_data_d  = ld_align;
               ld_valid_d = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         funct3_q     <= '0;
         addr_q       <= '0;
         is_store_q   <= 1'b0;
         dmem_valid_q <= 1'b0;
         dmem_we_q    <= 4'b0000;
         dmem_wdata_q <= '0;
         ld_valid_q   <= 1'b0;
         ld_data_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         is_store_q   <= is_store_d;
         dmem_valid_q <= dmem_valid_d;
         dmem_we_q    <= dmem_we_d;
         dmem_wdata_q <= dmem_wdata_d;
         ld_valid_q   <= ld_valid_d;
         ld_data_q    <= ld_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_err_q <= misalign_err_d;
`endif
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.dmem_valid = dmem_valid_q;
   assign bus.dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus.dmem_we    = dmem_we_q;
   assign bus.dmem_wdata = dmem_wdata_q;
   assign bus.ld_valid   = ld_valid_q;
   assign bus.ld_data    = ld_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign bus.misalign_err = misalign_err_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model and a per-cycle checker.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model expectations for the access currently in flight
   bit          m_active = 1'b0;
   bit          m_st = 1'b0;
   logic [31:0] m_addr = '0;
   logic [3:0]  m_we = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_ld = '0;
   logic [31:0] m_last_ld = '0;

   logic [31:0] obs_addr, obs_wdata, obs_ld;
   logic [3:0]  obs_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] mdl_we(input bit st, input logic [2:0] f3, input logic [31:0] a);
      int unsigned off = a % 4;
      if (!st) return 4'h0;
      if (f3 == 3'd0) return 4'(1 << off);
      if (f3 == 3'd1) return 4'(3 << ((off / 2) * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] r);
      int unsigned off = a % 4;
      int v;
      case (f3)
         3'd0, 3'd4: begin
            v = int'((r >> (8 * off)) & 32'hFF);
            if (f3 == 3'd0 && v >= 128) v = v - 256;
         end
         3'd1, 3'd5: begin
            v = int'((r >> (16 * (off / 2))) & 32'hFFFF);
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
         end
         default: v = int'(r);
      endcase
      return 32'(v);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         m_last_ld = '0;
      end else begin
         if (m_active && bus.dmem_valid) begin
            chk("dmem_addr", bus.dmem_addr, m_addr);
            chk("dmem_we", {28'd0, bus.dmem_we}, {28'd0, m_we});
            if (m_st) chk("dmem_wdata", bus.dmem_wdata, m_wdata);
         end
         if (bus.ld_valid) begin
            chk("ld_data", bus.ld_data, m_ld);
            m_last_ld = m_ld;
         end else begin
            chk("ld_data_hold", bus.ld_data, m_last_ld);
         end
      end
   end

   task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] r,
                         input int rdy_dly, input int rv_dly, input bit early_rv);
      m_st    = wr;
      m_addr  = a & ~32'h3;
      m_we    = mdl_we(wr, f3, a);
      m_wdata = mdl_wdata(f3, d);
      m_ld    = mdl_load(f3, a, r);
      chk("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.wdata     = d;
      step();
      bus.req_valid = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.addr      = 32'hFFFF_FFFF;
      bus.wdata     = 32'h0BAD_0BAD;
      m_active = 1'b1;
      for (int i = 0; i < rdy_dly; i++) begin
         chk("busy_req", bus.busy, 1);
         chk("dmem_valid_req", bus.dmem_valid, 1);
         step();
      end
      chk("busy_req", bus.busy, 1);
      chk("dmem_valid_req", bus.dmem_valid, 1);
      obs_addr  = bus.dmem_addr;
      obs_we    = bus.dmem_we;
      obs_wdata = bus.dmem_wdata;
      bus.dmem_ready = 1'b1;
      if (early_rv) begin
         bus.dmem_rvalid = 1'b1;
         bus.dmem_rdata  = ~r;
      end
      step();
      bus.dmem_ready  = 1'b0;
      bus.dmem_rvalid = 1'b0;
      m_active = 1'b0;
      chk("dmem_valid_drop", bus.dmem_valid, 0);
      if (wr) begin
         chk("store_back_idle", bus.req_ready, 1);
         chk("store_busy_low", bus.busy, 0);
      end else begin
         for (int i = 0; i < rv_dly; i++) begin
            chk("busy_wait", bus.busy, 1);
            chk("ld_valid_wait", bus.ld_valid, 0);
            step();
         end
         chk("busy_wait", bus.busy, 1);
         bus.dmem_rvalid = 1'b1;
         bus.dmem_rdata  = r;
         step();
         bus.dmem_rvalid = 1'b0;
         bus.dmem_rdata  = '0;
         chk("ld_valid_pulse", bus.ld_valid, 1);
         chk("busy_done", bus.busy, 1);
         obs_ld = bus.ld_data;
         step();
         chk("ld_valid_single", bus.ld_valid, 0);
         chk("load_back_idle", bus.req_ready, 1);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.funct3 = 3'd0;
      bus.addr = '0;
      bus.wdata = '0;
      bus.dmem_ready = 1'b0;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata = '0;
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_dmem_valid", bus.dmem_valid, 0);
      chk("rst_dmem_we", {28'd0, bus.dmem_we}, 32'd0);
      chk("rst_ld_valid", bus.ld_valid, 0);
      chk("rst_ld_data", bus.ld_data, 32'd0);
      rst_n = 1'b1;
      step();

      // SB byte lane 3
      run_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
      chk("sb_addr", obs_addr, 32'h0000_1000);
      chk("sb_we", {28'd0, obs_we}, 32'h8);
      chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);

      run_op(1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, 1'b0);
      chk("lb_data", obs_ld, 32'hFFFF_FF80);
      run_op(1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, 1'b0);
      chk("lbu_data", obs_ld, 32'h0000_0080);

      // Backpressure: five stalled cycles before the handshake
      run_op(1'b0, 1'b1, 3'd2, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0, 5, 0, 1'b0);
      run_op(1'b1, 1'b0, 3'd2, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 5, 1, 1'b0);

      // LH upper half, rvalid late, plus a stray rvalid on the handshake cycle
      run_op(1'b1, 1'b0, 3'd1, 32'h0000_3002, 32'h0, 32'h8001_1234, 0, 3, 1'b1);
      chk("lh_data", obs_ld, 32'hFFFF_8001);
      run_op(1'b1, 1'b0, 3'd5, 32'h0000_3000, 32'h0, 32'h8001_9234, 0, 0, 1'b0);
      chk("lhu_data", obs_ld, 32'h0000_9234);
      run_op(1'b0, 1'b1, 3'd1, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 1, 0, 1'b0);
      chk("sh_we", {28'd0, obs_we}, 32'hC);
      chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);

      // Read and write both set: store
      run_op(1'b1, 1'b1, 3'd0, 32'h0000_9001, 32'h0000_003C, 32'h0, 0, 0, 1'b0);
      chk("rw_we", {28'd0, obs_we}, 32'h2);
      chk("rw_wdata", obs_wdata, 32'h3C3C_3C3C);

      // Unknown funct3 behaves as a word
      run_op(1'b1, 1'b0, 3'd3, 32'h0000_8004, 32'h0, 32'h1234_5678, 0, 2, 1'b0);
      chk("unk_load", obs_ld, 32'h1234_5678);
      run_op(1'b0, 1'b1, 3'd4, 32'h0000_8008, 32'h0102_0304, 32'h0, 0, 0, 1'b0);
      chk("unk_store_we", {28'd0, obs_we}, 32'hF);

      // Request without a memory op is ignored
      bus.req_valid = 1'b1;
      bus.addr = 32'h0000_1234;
      step();
      bus.req_valid = 1'b0;
      chk("noop_busy", bus.busy, 0);
      chk("noop_dmem_valid", bus.dmem_valid, 0);
      step();
      chk("noop_busy2", bus.busy, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      bus.req_valid = 1'b1;
      bus.mem_read = 1'b1;
      bus.funct3 = 3'd2;
      bus.addr = 32'h0000_4002;
      step();
      bus.req_valid = 1'b0;
      bus.mem_read = 1'b0;
      chk("mis_err_pulse", bus.misalign_err, 1);
      chk("mis_dmem_valid", bus.dmem_valid, 0);
      chk("mis_idle", bus.req_ready, 1);
      step();
      chk("mis_err_clear", bus.misalign_err, 0);
      chk("mis_dmem_valid2", bus.dmem_valid, 0);
      chk("mis_busy", bus.busy, 0);
`else
      run_op(1'b1, 1'b0, 3'd2, 32'h0000_4002, 32'h0, 32'h89AB_CDEF, 0, 0, 1'b0);
      chk("mis_lw_addr", obs_addr, 32'h0000_4000);
      chk("mis_lw_data", obs_ld, 32'h89AB_CDEF);
      run_op(1'b0, 1'b1, 3'd1, 32'h0000_5001, 32'h0000_1357, 32'h0, 0, 0, 1'b0);
      chk("mis_sh_we", {28'd0, obs_we}, 32'h3);
`endif

      // Reset while waiting for read data
      bus.req_valid = 1'b1;
      bus.mem_read = 1'b1;
      bus.funct3 = 3'd2;
      bus.addr = 32'h0000_A000;
      step();
      bus.req_valid = 1'b0;
      bus.mem_read = 1'b0;
      bus.dmem_ready = 1'b1;
      step();
      bus.dmem_ready = 1'b0;
      chk("rstw_busy", bus.busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata = 32'h5555_5555;
      step();
      bus.dmem_rvalid = 1'b0;
      chk("rstw_ld_valid", bus.ld_valid, 0);
      chk("rstw_idle", bus.req_ready, 1);
      chk("rstw_busy_low", bus.busy, 0);
      chk("rstw_dmem_valid", bus.dmem_valid, 0);
      chk("rstw_ld_data", bus.ld_data, 32'd0);
      step();
      chk("rstw_ld_valid2", bus.ld_valid, 0);

      // Unit still works after the abandoned access
      run_op(1'b1, 1'b0, 3'd0, 32'h0000_B003, 32'h0, 32'h7F00_0000, 0, 0, 1'b0);
      chk("post_rst_lb", obs_ld, 32'h0000_007F);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
